nes_joypad_port: RTL and testbench

Consumes the two 10-bit joypad vectors produced by the PS/2 scanners in the device manager and presents them to the NES CPU as the standard controller registers at $4016/$4017. It provides the strobe latch, the two 8-bit serial shift registers, the turbo-button modulation and opposite-direction masking. It sits on the CPU-side register bus, in the CPU clock domain, next to the APU/IO register decode.

---
 rtl/nes_joypad_port.sv | 163 ++++++++++++++++
 tb/tb_nes_joypad_port.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_port.sv
// NES controller port registers at $4016/$4017: strobe latch, per-player serial
// shift registers, turbo modulation of A/B and optional opposite-direction masking.
module nes_joypad_port #(
  parameter int unsigned TURBO_DIV      = 4,
  parameter bit          BLOCK_OPPOSITE = 1'b1,
  parameter logic [2:0]  OPEN_BUS       = 3'b010
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [9:0]  i_jp_vector_1p,
  input  logic [9:0]  i_jp_vector_2p,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_wr,
  input  logic        i_rd,
  output logic [7:0]  o_rdata,
  output logic        o_rdata_vld,
  output logic        o_strobe
);

  localparam logic [15:0] ADDR_JOY1  = 16'h4016;
  localparam logic [15:0] ADDR_JOY2  = 16'h4017;
  localparam logic [7:0]  TURBO_LAST = 8'(TURBO_DIV - 1);

  // Bus decode
  logic       wr_hit;
  logic [1:0] rd_hit;
  logic       any_rd_hit;
  logic       strobe_set;
  logic       strobe_fall;

  logic       strobe_reg;
  logic       strobe_next;
  logic [7:0] turbo_cnt_reg;
  logic [7:0] turbo_cnt_next;
  logic       turbo_phase_reg;
  logic       turbo_phase_next;
  logic [7:0] rdata_reg;
  logic [7:0] rdata_next;
  logic       rdata_vld_reg;
  logic       rdata_vld_next;

  logic [1:0][9:0] jp_vec;
  logic [1:0]      serial_bit;
  logic            read_bit;
  logic            unused_wdata;

  assign wr_hit      = i_wr && (i_addr == ADDR_JOY1);
  assign rd_hit[0]   = i_rd && (i_addr == ADDR_JOY1);
  assign rd_hit[1]   = i_rd && (i_addr == ADDR_JOY2);
  assign any_rd_hit  = |rd_hit;
  assign strobe_set  = wr_hit && i_wdata[0];
  assign strobe_fall = wr_hit && strobe_reg && !i_wdata[0];

  assign jp_vec[0] = i_jp_vector_1p;
  assign jp_vec[1] = i_jp_vector_2p;

  // Only the strobe bit of the written byte is meaningful.
  assign unused_wdata = ^i_wdata[7:1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      logic       btn_a;
      logic       btn_b;
      logic       btn_up;
      logic       btn_down;
      logic       btn_left;
      logic       btn_right;
      logic [7:0] eff_byte;
      logic [7:0] shift_reg;
      logic [7:0] shift_next;

      always_comb begin
        btn_a     = jp_vec[gi][0] | (jp_vec[gi][8] & turbo_phase_reg);
        btn_b     = jp_vec[gi][1] | (jp_vec[gi][9] & turbo_phase_reg);
        btn_up    = jp_vec[gi][4];
        btn_down  = jp_vec[gi][5];
        btn_left  = jp_vec[gi][6];
        btn_right = jp_vec[gi][7];
        if (BLOCK_OPPOSITE && btn_up && btn_down) begin
          btn_up   = 1'b0;
          btn_down = 1'b0;
        end
        if (BLOCK_OPPOSITE && btn_left && btn_right) begin
          btn_left  = 1'b0;
          btn_right = 1'b0;
        end
        eff_byte = {btn_right, btn_left, btn_down, btn_up,
                    jp_vec[gi][3], jp_vec[gi][2], btn_b, btn_a};
      end

      // Strobe high reloads every cycle; a read in the same cycle as a strobe-set
      // write must not consume a bit.
      always_comb begin
        shift_next = shift_reg;
        if (strobe_reg) begin
          shift_next = eff_byte;
        end else if (rd_hit[gi] && !strobe_set) begin
          shift_next = {1'b1, shift_reg[7:1]};
        end
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          shift_reg <= 8'h00;
        end else begin
          shift_reg <= shift_next;
        end
      end

      assign serial_bit[gi] = shift_reg[0];
    end
  endgenerate

  assign read_bit = rd_hit[1] ? serial_bit[1] : serial_bit[0];

  always_comb begin
    strobe_next      = strobe_reg;
    turbo_cnt_next   = turbo_cnt_reg;
    turbo_phase_next = turbo_phase_reg;
    rdata_next       = rdata_reg;
    rdata_vld_next   = any_rd_hit;

    if (wr_hit) begin
      strobe_next = i_wdata[0];
    end

    // Turbo phase flips once every TURBO_DIV strobe falling edges.
    if (strobe_fall) begin
      if (turbo_cnt_reg == TURBO_LAST) begin
        turbo_cnt_next   = 8'h00;
        turbo_phase_next = !turbo_phase_reg;
      end else begin
        turbo_cnt_next = turbo_cnt_reg + 8'h01;
      end
    end

    if (any_rd_hit) begin
      rdata_next = {OPEN_BUS, 4'b0000, read_bit};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      strobe_reg      <= 1'b0;
      turbo_cnt_reg   <= 8'h00;
      turbo_phase_reg <= 1'b0;
      rdata_reg       <= 8'h00;
      rdata_vld_reg   <= 1'b0;
    end else begin
      strobe_reg      <= strobe_next;
      turbo_cnt_reg   <= turbo_cnt_next;
      turbo_phase_reg <= turbo_phase_next;
      rdata_reg       <= rdata_next;
      rdata_vld_reg   <= rdata_vld_next;
    end
  end

  assign o_rdata     = rdata_reg;
  assign o_rdata_vld = rdata_vld_reg;
  assign o_strobe    = strobe_reg;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Bench for nes_joypad_port: two instances (default parameters, and TURBO_DIV=2 with
// opposite-direction masking off) driven in lockstep and compared to a behavioural model.
module tb_nes_joypad_port;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  vec1 = '0;
  logic [9:0]  vec2 = '0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;

  logic [7:0]  rdata_a, rdata_b;
  logic        vld_a, vld_b, strobe_a, strobe_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nes_joypad_port dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_jp_vector_1p(vec1), .i_jp_vector_2p(vec2),
    .i_addr(addr), .i_wdata(wdata), .i_wr(wr), .i_rd(rd),
    .o_rdata(rdata_a), .o_rdata_vld(vld_a), .o_strobe(strobe_a)
  );

  nes_joypad_port #(.TURBO_DIV(2), .BLOCK_OPPOSITE(1'b0), .OPEN_BUS(3'b010)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_jp_vector_1p(vec1), .i_jp_vector_2p(vec2),
    .i_addr(addr), .i_wdata(wdata), .i_wr(wr), .i_rd(rd),
    .o_rdata(rdata_b), .o_rdata_vld(vld_b), .o_strobe(strobe_b)
  );

  // Model: each player's latched byte plus how many bits have been read out of it.
  int         div_of [2] = '{4, 2};
  bit         blk_of [2] = '{1'b1, 1'b0};
  logic [7:0] m_byte [2][2];
  int         m_idx  [2][2];
  int         m_falls;
  bit         m_strobe;
  logic [7:0] m_rdata [2];
  bit         m_vld;

  function automatic bit m_phase(input int d);
    return ((m_falls / div_of[d]) % 2) == 1;
  endfunction

  function automatic logic [7:0] eff(input logic [9:0] v, input bit ph, input bit blk);
    bit a, b, up, dn, lf, rt;
    a  = v[0] || (v[8] && ph);
    b  = v[1] || (v[9] && ph);
    up = v[4]; dn = v[5]; lf = v[6]; rt = v[7];
    if (blk && up && dn) begin up = 0; dn = 0; end
    if (blk && lf && rt) begin lf = 0; rt = 0; end
    return {rt, lf, dn, up, v[3], v[2], b, a};
  endfunction

  function automatic bit model_bit(input int d, input int p);
    if (m_idx[d][p] >= 8) return 1'b1;
    return m_byte[d][p][m_idx[d][p]];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        m_byte[d][p] = 8'h00;
        m_idx[d][p]  = 0;
      end
      m_rdata[d] = 8'h00;
    end
    m_falls  = 0;
    m_strobe = 0;
    m_vld    = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_dut(input string tag);
    chk($sformatf("%s_a_vld", tag), {7'd0, vld_a}, {7'd0, m_vld});
    chk($sformatf("%s_b_vld", tag), {7'd0, vld_b}, {7'd0, m_vld});
    chk($sformatf("%s_a_rdata", tag), rdata_a, m_rdata[0]);
    chk($sformatf("%s_b_rdata", tag), rdata_b, m_rdata[1]);
    chk($sformatf("%s_a_strobe", tag), {7'd0, strobe_a}, {7'd0, m_strobe});
    chk($sformatf("%s_b_strobe", tag), {7'd0, strobe_b}, {7'd0, m_strobe});
  endtask

  task automatic check_reset_values(input string tag);
    chk($sformatf("%s_a_rdata", tag), rdata_a, 8'h00);
    chk($sformatf("%s_b_rdata", tag), rdata_b, 8'h00);
    chk($sformatf("%s_a_vld", tag), {7'd0, vld_a}, 8'h00);
    chk($sformatf("%s_b_vld", tag), {7'd0, vld_b}, 8'h00);
    chk($sformatf("%s_a_strobe", tag), {7'd0, strobe_a}, 8'h00);
    chk($sformatf("%s_b_strobe", tag), {7'd0, strobe_b}, 8'h00);
  endtask

  // One bus cycle: drive, advance the model, clock, compare.
  task automatic tick(input logic [15:0] a, input bit w, input bit r, input logic [7:0] wd,
                      input string tag);
    bit wh;
    int rp;
    addr  = a;
    wr    = w;
    rd    = r;
    wdata = wd;
    wh = w && (a == 16'h4016);
    rp = -1;
    if (r && a == 16'h4016) rp = 0;
    else if (r && a == 16'h4017) rp = 1;
    m_vld = (rp >= 0);
    for (int d = 0; d < 2; d++) begin
      if (rp >= 0) m_rdata[d] = {3'b010, 4'b0000, model_bit(d, rp)};
      for (int p = 0; p < 2; p++) begin
        if (m_strobe) begin
          m_byte[d][p] = eff(p == 0 ? vec1 : vec2, m_phase(d), blk_of[d]);
          m_idx[d][p]  = 0;
        end else if (rp == p && !(wh && wd[0])) begin
          if (m_idx[d][p] < 8) m_idx[d][p]++;
        end
      end
    end
    if (wh) begin
      if (m_strobe && !wd[0]) m_falls++;
      m_strobe = wd[0];
    end
    @(posedge clk);
    #1;
    check_dut(tag);
    if (w || r)
      $display("txn %-8s addr=%h wr=%0d rd=%0d wdata=%h | a: vld=%0d rdata=%h strobe=%0d | b: vld=%0d rdata=%h strobe=%0d",
               tag, a, w, r, wd, vld_a, rdata_a, strobe_a, vld_b, rdata_b, strobe_b);
    wr = 0;
    rd = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    wr = 0;
    rd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rstn = 1;
  endtask

  initial begin
    int seq_a [10] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    int seq_t [8]  = '{0, 0, 1, 1, 0, 0, 1, 1};
    model_reset();

    // Reset state and first read
    do_reset();
    tick(16'h4016, 0, 1, 8'h00, "rd_rst");
    chk("rd_rst_const", rdata_a, 8'h40);

    // A+Start serial sequence
    vec1 = 10'h009;
    tick(16'h4016, 1, 0, 8'h01, "wr1");
    tick(16'h4016, 1, 0, 8'h00, "wr0");
    for (int i = 0; i < 10; i++) begin
      tick(16'h4016, 0, 1, 8'h00, "rd_seq");
      chk($sformatf("seq_bit%0d", i), {7'd0, rdata_a[0]}, 8'(seq_a[i]));
    end

    // Strobe held high, A toggling every cycle
    tick(16'h4016, 1, 0, 8'h01, "wr1");
    for (int i = 0; i < 8; i++) begin
      vec1 = vec1 ^ 10'h001;
      tick(16'h4016, 0, 1, 8'h00, "rd_hold");
    end
    tick(16'h4016, 1, 0, 8'h00, "wr0");

    // Up+Down on player 2: masked in dut_a, visible in dut_b
    vec2 = 10'h030;
    tick(16'h4016, 1, 0, 8'h01, "wr1");
    tick(16'h4016, 1, 0, 8'h00, "wr0");
    for (int i = 0; i < 8; i++) tick(16'h4017, 0, 1, 8'h00, "rd_opp");

    // Turbo A frames
    do_reset();
    vec1 = 10'h100;
    vec2 = 10'h000;
    for (int f = 0; f < 8; f++) begin
      tick(16'h4016, 1, 0, 8'h01, "wr1");
      tick(16'h4016, 1, 0, 8'h00, "wr0");
      tick(16'h4016, 0, 1, 8'h00, "rd_turbo");
      chk($sformatf("turbo_frame%0d", f), {7'd0, rdata_b[0]}, 8'(seq_t[f]));
    end

    // Asynchronous reset mid-shift
    vec1 = 10'h0FF;
    tick(16'h4016, 1, 0, 8'h01, "wr1");
    tick(16'h4016, 1, 0, 8'h00, "wr0");
    for (int i = 0; i < 3; i++) tick(16'h4016, 0, 1, 8'h00, "rd_ff");
    #3;
    rstn = 0;
    model_reset();
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    rstn = 1;
    tick(16'h4016, 0, 1, 8'h00, "rd_post");
    chk("rd_post_const", rdata_b, 8'h40);
    tick(16'h4016, 1, 0, 8'h01, "wr1");
    tick(16'h4016, 1, 0, 8'h00, "wr0");
    for (int i = 0; i < 8; i++) tick(16'h4016, 0, 1, 8'h00, "rd_ff2");

    // Random bus traffic
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) begin
        vec1 = 10'($urandom);
        vec2 = 10'($urandom);
      end
      case (op)
        0, 1:    tick(16'h4016, 1, 0, 8'($urandom), "r_wr");
        2:       tick(16'h4017, 1, 0, 8'($urandom), "r_wr17");
        3:       tick(16'h4016, 1, 1, 8'($urandom), "r_wrrd");
        4, 5:    tick(16'h4016, 0, 1, 8'h00, "r_rd16");
        6, 7:    tick(16'h4017, 0, 1, 8'h00, "r_rd17");
        8:       tick(16'($urandom_range(16'h4010, 16'h401F)), 0, 1, 8'h00, "r_rdx");
        default: tick(16'h0000, 0, 0, 8'h00, "r_idle");
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
